// File: rtl/matrix_pkg.sv
// Shared dimensions, scan-state encoding and column-index helpers for the LED matrix scan driver.
package matrix_pkg;

  localparam int MATRIX_ROWS = 7;
  localparam int MATRIX_COLS = 5;
  localparam int COL_IDX_W   = $clog2(MATRIX_COLS);

  typedef enum logic [1:0] {
    SCAN_IDLE  = 2'd0,
    SCAN_DRIVE = 2'd1,
    SCAN_BLANK = 2'd2
  } scan_state_e;

  typedef logic [MATRIX_ROWS-1:0] row_t;
  typedef logic [MATRIX_COLS-1:0] col_sel_t;
  typedef logic [COL_IDX_W-1:0]   col_idx_t;
  // Packed so that element k holds column_k; 35 bits in total.
  typedef row_t [MATRIX_COLS-1:0] frame_t;

  function automatic col_idx_t next_col(input col_idx_t idx);
    return (idx == col_idx_t'(MATRIX_COLS - 1)) ? '0 : idx + col_idx_t'(1);
  endfunction

  function automatic col_sel_t col_onehot(input col_idx_t idx);
    return col_sel_t'(1) << idx;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Down-counter for the dwell/blank phases: load a length, done is high in the last clock of it.
module scan_timer #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // NOTE: sequential state is only ever updated with non-blocking assignments.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A phase loaded with N runs for counts N..1, so N clocks end when the count reads 1.
  assign done = (count_q == WIDTH'(1));

endmodule

// File: rtl/matrix_scan_driver.sv
// 5x7 LED matrix column scanner: snapshots a frame at column 0 and drives one column at a time.
module matrix_scan_driver
  import matrix_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [MATRIX_ROWS-1:0] column_0,
  input  logic [MATRIX_ROWS-1:0] column_1,
  input  logic [MATRIX_ROWS-1:0] column_2,
  input  logic [MATRIX_ROWS-1:0] column_3,
  input  logic [MATRIX_ROWS-1:0] column_4,
  output logic [MATRIX_ROWS-1:0] matrix_row,
  output logic [MATRIX_COLS-1:0] matrix_col,
  output logic                   frame_start
);

  localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  scan_state_e state_q, state_d;
  col_idx_t    idx_q, idx_d;
  frame_t      buffer_q, buffer_d;
  row_t        row_q, row_d;
  col_sel_t    col_q, col_d;
  logic        frame_start_q, frame_start_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_done;
  logic             advance;
  frame_t           snapshot;

  assign snapshot = {column_4, column_3, column_2, column_1, column_0};

  scan_timer #(
    .WIDTH (CNT_W)
  ) u_scan_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (tmr_load),
    .load_value (tmr_value),
    .done       (tmr_done)
  );

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    buffer_d      = buffer_q;
    frame_start_d = 1'b0;
    tmr_load      = 1'b0;
    tmr_value     = '0;
    advance       = 1'b0;

    if (!enable) begin
      // Abandon the frame; loading zero parks the dwell counter at 0 while idle.
      state_d  = SCAN_IDLE;
      idx_d    = '0;
      tmr_load = 1'b1;
    end else begin
      case (state_q)
        SCAN_IDLE: begin
          state_d       = SCAN_DRIVE;
          idx_d         = '0;
          buffer_d      = snapshot;
          frame_start_d = 1'b1;
          tmr_load      = 1'b1;
          tmr_value     = CNT_W'(DWELL_CYCLES);
        end
        SCAN_DRIVE: begin
          if (tmr_done) begin
            if (BLANK_CYCLES == 0) begin
              advance = 1'b1;
            end else begin
              state_d   = SCAN_BLANK;
              tmr_load  = 1'b1;
              tmr_value = CNT_W'(BLANK_CYCLES);
            end
          end
        end
        SCAN_BLANK: begin
          if (tmr_done) begin
            advance = 1'b1;
          end
        end
        default: state_d = SCAN_IDLE;
      endcase

      if (advance) begin
        state_d   = SCAN_DRIVE;
        idx_d     = next_col(idx_q);
        tmr_load  = 1'b1;
        tmr_value = CNT_W'(DWELL_CYCLES);
        if (idx_d == '0) begin
          buffer_d      = snapshot;
          frame_start_d = 1'b1;
        end
      end
    end
  end

  // Outputs decode the next state so they change on the same edge as the state register.
  always_comb begin
    row_d = '0;
    col_d = '0;
    if (state_d == SCAN_DRIVE) begin
      row_d = buffer_d[idx_d];
      col_d = col_onehot(idx_d);
    end
  end

  // NOTE: the frame buffer is reset along with the control state, so nothing stale is shown after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= SCAN_IDLE;
      idx_q         <= '0;
      buffer_q      <= '0;
      row_q         <= '0;
      col_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      buffer_q      <= buffer_d;
      row_q         <= row_d;
      col_q         <= col_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign matrix_row  = row_q;
  assign matrix_col  = col_q;
  assign frame_start = frame_start_q;

endmodule
